// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU/DMA) arbiter onto a single fixed-latency memory port.
// Define ARB_RR_EN for round-robin on simultaneous requests; default is fixed CPU priority.
module mem_port_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant_cpu,
  output logic          grant_dma
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } state_e;

  localparam logic [2:0] LastCnt = 3'(LAT - 1);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;  // 1 = DMA owns the access
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          win_dma;
`ifdef ARB_RR_EN
  logic          last_q, last_d;  // 1 = DMA was granted last
`endif

  always_comb begin
`ifdef ARB_RR_EN
    // On a tie the requester that was not granted last wins.
    win_dma = dma_req & (~cpu_req | ~last_q);
`else
    win_dma = dma_req & ~cpu_req;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
`ifdef ARB_RR_EN
    last_d      = last_q;
`endif
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_ready   = 1'b0;
    dma_ready   = 1'b0;
    grant_cpu   = 1'b0;
    grant_dma   = 1'b0;

    case (state_q)
      StIdle: begin
        if (cpu_req || dma_req) begin
          owner_d = win_dma;
          we_d    = win_dma ? dma_we    : cpu_we;
          addr_d  = win_dma ? dma_addr  : cpu_addr;
          wdata_d = win_dma ? dma_wdata : cpu_wdata;
          cnt_d   = 3'd0;
          state_d = StAccess;
`ifdef ARB_RR_EN
          last_d  = win_dma;
`endif
        end
      end
      StAccess: begin
        mem_re    = ~we_q;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        grant_cpu = ~owner_q;
        grant_dma = owner_q;
        if (cnt_q == LastCnt) begin
          if (!we_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StResp: begin
        cpu_ready = ~owner_q;
        dma_ready = owner_q;
        grant_cpu = ~owner_q;
        grant_dma = owner_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
`ifdef ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases and random traffic
// checked against a transaction-level model; a second LAT=1 instance covers back-to-back timing.
module tb_mem_port_arbiter;

  localparam int unsigned L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;

  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ready, dma_ready, mem_re, mem_we, grant_cpu, grant_dma;
  logic [31:0] cpu_rdata_1, dma_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic        cpu_ready_1, dma_ready_1, mem_re_1, mem_we_1, grant_cpu_1, grant_dma_1;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_cpu_rd, exp_dma_rd;
  logic        last_dma;

  always #5 clk = ~clk;

  // Memory contents as seen by the requesters: a fixed address-derived pattern.
  function automatic logic [31:0] pat(input logic [31:0] a);
    if (a == 32'h40) return 32'h1234ABCD;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  assign mem_rdata   = pat(mem_addr);
  assign mem_rdata_1 = pat(mem_addr_1);

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(L)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_cpu(grant_cpu), .grant_dma(grant_dma)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_1), .cpu_ready(cpu_ready_1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata_1), .dma_ready(dma_ready_1),
    .mem_re(mem_re_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .grant_cpu(grant_cpu_1), .grant_dma(grant_dma_1)
  );

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        exp_dma;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Winner for a request pair, from the arbitration rules.
  function automatic logic arb_dma(input logic c, input logic d);
    if (c && d) begin
`ifdef ARB_RR_EN
      return !last_dma;
`else
      return 1'b0;
`endif
    end
    return d;
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset      = 1'b0;
    exp_cpu_rd = '0;
    exp_dma_rd = '0;
    last_dma   = 1'b1;
  endtask

  // Called at a negedge of an IDLE cycle with the request already applied.
  task automatic run_txn(input string tag, input logic dma, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic drop);
    for (int k = 1; k <= int'(L); k++) begin
      @(negedge clk);
      chk({tag, " mem_re"}, 64'(mem_re), 64'(!we));
      chk({tag, " mem_we"}, 64'(mem_we), 64'(we));
      chk({tag, " mem_addr"}, 64'(mem_addr), 64'(addr));
      if (we) chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(wdata));
      chk({tag, " grants"}, 64'({grant_cpu, grant_dma}), 64'({!dma, dma}));
      chk({tag, " early ready"}, 64'({cpu_ready, dma_ready}), 64'd0);
      if (drop && k == 1) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
    end
    @(negedge clk);
    if (!we) begin
      if (dma) exp_dma_rd = pat(addr);
      else     exp_cpu_rd = pat(addr);
    end
    chk({tag, " ready"}, 64'({cpu_ready, dma_ready}), 64'({!dma, dma}));
    chk({tag, " resp strobes"}, 64'({mem_re, mem_we}), 64'd0);
    chk({tag, " resp grants"}, 64'({grant_cpu, grant_dma}), 64'({!dma, dma}));
    chk({tag, " cpu_rdata"}, 64'(cpu_rdata), 64'(exp_cpu_rd));
    chk({tag, " dma_rdata"}, 64'(dma_rdata), 64'(exp_dma_rd));
    last_dma = dma;
  endtask

  task automatic to_idle(input string tag);
    @(negedge clk);
    chk({tag, " idle outs"},
        64'({mem_re, mem_we, cpu_ready, dma_ready, grant_cpu, grant_dma}), 64'd0);
    chk({tag, " idle addr"}, 64'(mem_addr), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic e;
    logic pend_c, pend_d;
    int   t1, t2;

    vecs[0] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h80, 32'hDEADBEEF, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 32'h10, 32'h11112222, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h84, 32'h0,        1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'hFC, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h40, 32'h0,        1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h44, 32'h5555AAAA, 1'b1};

    do_reset();
    chk("reset outs", 64'({mem_re, mem_we, cpu_ready, dma_ready, grant_cpu, grant_dma}), 64'd0);
    chk("reset rdata", 64'({cpu_rdata, dma_rdata}), 64'd0);
    chk("reset mem_addr/wdata", 64'({mem_addr, mem_wdata}), 64'd0);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      cpu_req = vecs[i].c_req; cpu_we = vecs[i].c_we;
      cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wdata;
      dma_req = vecs[i].d_req; dma_we = vecs[i].d_we;
      dma_addr = vecs[i].d_addr; dma_wdata = vecs[i].d_wdata;
      run_txn($sformatf("vec%0d", i), vecs[i].exp_dma,
              vecs[i].exp_dma ? vecs[i].d_we : vecs[i].c_we,
              vecs[i].exp_dma ? vecs[i].d_addr : vecs[i].c_addr,
              vecs[i].exp_dma ? vecs[i].d_wdata : vecs[i].c_wdata, 1'b0);
      cpu_req = 1'b0;
      dma_req = 1'b0;
      to_idle($sformatf("vec%0d", i));
    end
    chk("scenario cpu_rdata 0x40", 64'(cpu_rdata), 64'h1234ABCD);

    // Both requests held high across four accesses
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      e = (i % 2) == 1;
`else
      e = 1'b0;
`endif
      run_txn($sformatf("both%0d", i), e, 1'b0, e ? 32'h200 : 32'h100, 32'h0, 1'b0);
      to_idle($sformatf("both%0d", i));
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);

    // Reset during the first access cycle abandons the read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    run_txn("pre-reset", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
    to_idle("pre-reset");
    cpu_addr = 32'h8;
    @(negedge clk);
    chk("rst access mem_re", 64'(mem_re), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst mem_re drop", 64'({mem_re, grant_cpu, cpu_ready}), 64'd0);
    chk("rst cpu_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cpu_req = 1'b0;
    exp_cpu_rd = '0; exp_dma_rd = '0; last_dma = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst no ready", 64'({cpu_ready, mem_re, grant_cpu}), 64'd0);
    end

    // Request dropped after the first access cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    run_txn("drop", 1'b0, 1'b0, 32'h80, 32'h0, 1'b1);
    to_idle("drop");
    to_idle("drop2");

    // Random traffic, requesters hold req until served
    pend_c = 1'b0;
    pend_d = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!pend_c) begin
        cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = {20'd0, 10'($urandom_range(0, 1023)), 2'b00}; cpu_wdata = $urandom;
      end
      if (!pend_d) begin
        dma_req = 1'($urandom_range(0, 1)); dma_we = 1'($urandom_range(0, 1));
        dma_addr = {20'd0, 10'($urandom_range(0, 1023)), 2'b00}; dma_wdata = $urandom;
      end
      if (!cpu_req && !dma_req) begin
        to_idle("rnd none");
        continue;
      end
      e = arb_dma(cpu_req, dma_req);
      run_txn($sformatf("rnd%0d", n), e, e ? dma_we : cpu_we, e ? dma_addr : cpu_addr,
              e ? dma_wdata : cpu_wdata, 1'b0);
      if (e) dma_req = 1'b0;
      else   cpu_req = 1'b0;
      pend_c = cpu_req;
      pend_d = dma_req;
      to_idle($sformatf("rnd%0d", n));
    end

    // LAT=1 back-to-back CPU reads on the second instance
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (cpu_ready_1) begin
        if (t1 == 0) begin
          t1 = i;
          chk("lat1 rdata0", 64'(cpu_rdata_1), 64'(pat(32'h0)));
          cpu_addr = 32'h4;
        end else if (t2 == 0) begin
          t2 = i;
          chk("lat1 rdata4", 64'(cpu_rdata_1), 64'(pat(32'h4)));
          cpu_req = 1'b0;
        end
      end
    end
    chk("lat1 first ready cycle", 64'(t1), 64'd2);
    chk("lat1 second ready cycle", 64'(t2), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width.
REQ-003 The block SHALL have parameter LAT, default 2, meaning memory access cycles; legal range 1..7.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in AW and cpu_wdata in DW, carrying the multicycle CPU request (cpu_we=1 write, 0 read).
REQ-007 The block SHALL have ports cpu_rdata out DW and cpu_ready out 1, carrying the CPU response.
REQ-008 The block SHALL have ports dma_req in 1, dma_we in 1, dma_addr in AW, dma_wdata in DW, dma_rdata out DW and dma_ready out 1, the DMA requester's equivalents.
REQ-009 The block SHALL have ports mem_re out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW and mem_rdata in DW, the shared unified memory port.
REQ-010 The block SHALL have ports grant_cpu out 1 and grant_dma out 1, indicating the current access owner.

Function
REQ-011 The FSM SHALL have states IDLE, ACCESS and RESP, 2-bit encoded as IDLE=00, ACCESS=01, RESP=10; code 11 SHALL go to IDLE.
REQ-012 In IDLE with no request, the FSM SHALL stay in IDLE and drive all mem_* and ready outputs 0.
REQ-013 In IDLE with any req, the FSM SHALL latch owner, we, addr and wdata from the winner, clear the cycle counter and enter ACCESS.
REQ-014 In ACCESS, the block SHALL hold mem_addr and mem_wdata from the latched values and hold mem_re=~we or mem_we=we (one-hot) for exactly LAT cycles.
REQ-015 On the LAT-th ACCESS cycle, the block SHALL capture mem_rdata into the owner's rdata register (reads only) and enter RESP.
REQ-016 In RESP, the block SHALL assert the owner's ready for exactly one cycle and then return to IDLE.
REQ-017 Latency SHALL be: req sampled in IDLE at edge N, strobes active cycles N+1..N+LAT, ready high cycle N+LAT+1; one access per LAT+2 cycles.
REQ-018 rdata SHALL hold its value until that requester's next read completes; writes SHALL leave rdata unchanged.
REQ-019 Requesters SHALL hold req and payload until ready; the block SHALL sample the payload only in IDLE.
REQ-020 A req deasserting mid-access SHALL NOT abort the access; ready SHALL still pulse.
REQ-021 A req still high in the RESP cycle SHALL be re-arbitrated in the following IDLE cycle as a new access.
REQ-022 grant_cpu/grant_dma SHALL be one-hot in ACCESS and RESP, and both 0 in IDLE.
REQ-023 Without the macro of REQ-027, CPU SHALL win when both requests are high.

Reset
REQ-024 Reset SHALL act immediately, mid-access included: state=IDLE, counter=0, all mem strobes, ready and grant outputs 0.
REQ-025 Reset SHALL set cpu_rdata, dma_rdata, mem_addr and mem_wdata to 0, and last_owner to DMA.
REQ-026 An access interrupted by reset SHALL be abandoned; no ready SHALL be issued for it.

Configuration
REQ-027 With ARB_RR_EN defined, a simultaneous request SHALL be granted to the requester not in last_owner; last_owner updates on each grant; single requests SHALL be granted as without the macro.
REQ-028 Without ARB_RR_EN, last_owner logic SHALL be absent and arbitration SHALL be fixed CPU priority.

Verification
REQ-029 Scenario: CPU read addr 0x40, mem_rdata=0x1234ABCD, LAT=2 -> mem_re high 2 cycles with mem_addr 0x40, cpu_ready pulse at N+3, cpu_rdata=0x1234ABCD.
REQ-030 Scenario: DMA write addr 0x80 data 0xDEADBEEF -> mem_we high LAT cycles, mem_wdata 0xDEADBEEF, dma_ready one pulse, dma_rdata unchanged.
REQ-031 Scenario: both req held high for 4 accesses -> fixed build grants CPU,CPU,CPU,CPU; ARB_RR_EN build grants CPU,DMA,CPU,DMA.
REQ-032 Scenario: reset asserted on the 1st ACCESS cycle of a CPU read -> mem_re drops the same cycle, no cpu_ready, state IDLE, rdata 0.
REQ-033 Scenario: cpu_req dropped after the first ACCESS cycle -> access completes, cpu_ready pulses once, then IDLE with strobes 0.
REQ-034 Scenario: LAT=1 back-to-back CPU reads at 0x0 and 0x4 -> ready pulses 3 cycles apart, each rdata matching the memory model.
